// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-and-add multiplier with a start/busy/done handshake.
// One multiplier bit is retired per clock, and the run ends early once the remaining multiplier bits are zero.
`default_nettype none

module shift_add_multiplier #(
  parameter int size = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [size-1:0]     multiplicand,
  input  logic [size-1:0]     multiplier,
  output logic                busy,
  output logic                done,
  output logic [2*size-1:0]   product
);

  localparam int CW = $clog2(size) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [2*size-1:0]   mcand_r;
  logic [2*size-1:0]   acc_r;
  logic [size-1:0]     mplier_r;
  logic [CW-1:0]       cnt;
  logic                zero_operand;
  logic                run_last;

  assign zero_operand = (multiplicand == '0) || (multiplier == '0);
  // Last RUN cycle: either no set bits remain above bit 0, or all bits have been consumed.
  assign run_last     = ((mplier_r >> 1) == '0) || (cnt == CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = zero_operand ? DONE : RUN;
      end
      RUN: begin
        if (run_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand_r  <= {{size{1'b0}}, multiplicand};
            mplier_r <= multiplier;
            acc_r    <= '0;
            cnt      <= CW'(size);
          end
        end
        RUN: begin
          if (mplier_r[0]) acc_r <= acc_r + mcand_r;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt      <= cnt - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign product = acc_r;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: vector table plus hand-written handshake/reset sequences.
`default_nettype none

module tb_shift_add_multiplier;

  localparam int SIZE = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [SIZE-1:0]   multiplicand;
  logic [SIZE-1:0]   multiplier;
  logic              busy;
  logic              done;
  logic [2*SIZE-1:0] product;

  always #5 clk = ~clk;

  shift_add_multiplier #(.size(SIZE)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  typedef struct {
    logic [SIZE-1:0]   a;
    logic [SIZE-1:0]   b;
    logic [2*SIZE-1:0] p;
    int                n;
  } vec_t;

  typedef struct {
    logic [2*SIZE-1:0] p;
    int                n;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   busy_cnt = 0;
  int   done_seen = 0;
  logic prev_busy = 1'b0;

  task automatic check(input string name, input logic [2*SIZE-1:0] act, input logic [2*SIZE-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and scores each done pulse against the queue.
  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      exp_t e;
      if (busy && done) check("busy_done_overlap", 64'(busy & done), 64'd0);
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          check("product", product, e.p);
          check("busy_cycles", 64'(busy_cnt), 64'(e.n));
          check("done_follows_busy", 64'(prev_busy), 64'(e.n > 0));
        end
        busy_cnt = 0;
        done_seen++;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < 80 && done_seen < target; i++) @(posedge clk);
    if (done_seen < target) check({name, "_timeout"}, 64'(done_seen), 64'(target));
  endtask

  task automatic run_op(input vec_t v, input string name);
    int t;
    exp_t e;
    t = done_seen;
    @(negedge clk);
    multiplicand = v.a;
    multiplier   = v.b;
    start        = 1'b1;
    e.p = v.p;
    e.n = v.n;
    sb.push_back(e);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = ~v.a;
    multiplier   = ~v.b;
    wait_done(t + 1, name);
  endtask

  vec_t vecs[10];

  initial begin
    int t;
    exp_t e;
    vecs[0] = '{a: 32'd6,          b: 32'd7,          p: 64'd42,                  n: 3};
    vecs[1] = '{a: 32'd0,          b: 32'd123,        p: 64'd0,                   n: 0};
    vecs[2] = '{a: 32'd123,        b: 32'd0,          p: 64'd0,                   n: 0};
    vecs[3] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   p: 64'hFFFFFFFE00000001,    n: 32};
    vecs[4] = '{a: 32'd3,          b: 32'h80000000,   p: 64'h180000000,           n: 32};
    vecs[5] = '{a: 32'h80000000,   b: 32'd1,          p: 64'h80000000,            n: 1};
    vecs[6] = '{a: 32'd1,          b: 32'd1,          p: 64'd1,                   n: 1};
    vecs[7] = '{a: 32'd12,         b: 32'd12,         p: 64'd144,                 n: 4};
    vecs[8] = '{a: 32'h0000FFFF,   b: 32'h00010000,   p: 64'hFFFF0000,            n: 17};
    vecs[9] = '{a: 32'h12345678,   b: 32'd9,          p: 64'hA3D70A38,            n: 4};

    reset = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // First vector with a hold check: product must stay put while idle.
    run_op(vecs[0], "v0");
    repeat (10) @(negedge clk);
    check("product_hold", product, 64'd42);
    check("idle_busy", 64'(busy), 64'd0);

    for (int i = 1; i < 10; i++) run_op(vecs[i], $sformatf("v%0d", i));

    // Back-to-back: start held high through RUN and DONE with different operands.
    t = done_seen;
    @(negedge clk);
    multiplicand = 32'd5;
    multiplier   = 32'd9;
    start        = 1'b1;
    e.p = 64'd45; e.n = 4; sb.push_back(e);
    @(negedge clk);
    multiplicand = 32'd2;
    multiplier   = 32'd2;
    e.p = 64'd4;  e.n = 2; sb.push_back(e);
    wait_done(t + 1, "b2b_first");
    @(negedge clk);
    check("b2b_idle_gap_busy", 64'(busy), 64'd0);
    check("b2b_idle_gap_done", 64'(done), 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_accepted", 64'(busy), 64'd1);
    wait_done(t + 2, "b2b_second");
    repeat (4) @(negedge clk);
    check("b2b_no_extra_done", 64'(done_seen), 64'(t + 2));

    // Asynchronous reset during RUN cycle 4.
    t = done_seen;
    @(negedge clk);
    multiplicand = 32'd1000;
    multiplier   = 32'd1000;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_done", 64'(done), 64'd0);
    check("async_reset_product", product, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_no_done", 64'(done_seen), 64'(t));
    run_op(vecs[7], "after_reset");

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
